// File: rtl/code_loader.sv
// Byte-stream code loader: assembles little-endian words into code memory and holds the CPU in reset until the image is in.
// Optional trailing XOR checksum byte enabled by defining CODE_LOADER_CHECKSUM_EN.
module code_loader #(
   parameter int CODE_WORDS = 512,
   parameter int ADDR_W     = 9
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wd,
   output logic              cpu_resetn,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

`ifdef CODE_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} stateType;
   localparam stateType S_TAIL     = S_CSUM;
   localparam logic     TAIL_READY = 1'b1;
`else
   typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR} stateType;
   localparam stateType S_TAIL     = S_DONE;
   localparam logic     TAIL_READY = 1'b0;
`endif

   localparam logic [15:0] MAX_WORDS = 16'(CODE_WORDS);

   stateType          r_state;
   logic [15:0]       r_len;
   logic [1:0]        r_byteIdx;
   logic [23:0]       r_asm;
   logic              r_inReady;
   logic              r_memWe;
   logic [ADDR_W-1:0] r_memAddr;
   logic [31:0]       r_memWd;
   logic              r_cpuResetn;
   logic              r_done;
   logic              r_error;
   logic [ADDR_W:0]   r_wordsLoaded;
`ifdef CODE_LOADER_CHECKSUM_EN
   logic [7:0]        r_xor;
`endif

   logic              w_xfer;
   logic [15:0]       w_len;
   logic              w_lastWord;
   logic              w_moreWords;

   assign w_xfer      = in_valid & r_inReady;
   assign w_len       = {in_data, r_len[7:0]};
   // words_loaded already counts every earlier word by the time a later word's 4th byte arrives
   assign w_lastWord  = ((16'(r_wordsLoaded) + 16'd1) == r_len);
   assign w_moreWords = (16'(r_wordsLoaded) < r_len);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state       <= S_LEN0;
         r_len         <= '0;
         r_byteIdx     <= '0;
         r_asm         <= '0;
         r_inReady     <= 1'b0;
         r_memWe       <= 1'b0;
         r_memAddr     <= '0;
         r_memWd       <= '0;
         r_cpuResetn   <= 1'b0;
         r_done        <= 1'b0;
         r_error       <= 1'b0;
         r_wordsLoaded <= '0;
`ifdef CODE_LOADER_CHECKSUM_EN
         r_xor         <= '0;
`endif
      end else begin
         r_memWe     <= 1'b0;
         r_done      <= (r_state == S_DONE);
         r_error     <= (r_state == S_ERR);
         r_cpuResetn <= (r_state == S_DONE);
         // Address advances only while words remain, so a full memory never wraps to 0
         if (r_memWe && w_moreWords) begin
            r_memAddr <= r_memAddr + ADDR_W'(1);
         end
         case (r_state)
            S_LEN0: begin
               r_inReady <= 1'b1;
               if (w_xfer) begin
                  r_len[7:0] <= in_data;
                  r_state    <= S_LEN1;
               end
            end
            S_LEN1: begin
               if (w_xfer) begin
                  r_len[15:8] <= in_data;
                  if (w_len == 16'd0) begin
                     r_state   <= S_TAIL;
                     r_inReady <= TAIL_READY;
                  end else if (w_len > MAX_WORDS) begin
                     r_state   <= S_ERR;
                     r_inReady <= 1'b0;
                  end else begin
                     r_state   <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_byteIdx <= r_byteIdx + 2'd1;
`ifdef CODE_LOADER_CHECKSUM_EN
                  r_xor     <= r_xor ^ in_data;
`endif
                  case (r_byteIdx)
                     2'd0: r_asm[7:0]   <= in_data;
                     2'd1: r_asm[15:8]  <= in_data;
                     2'd2: r_asm[23:16] <= in_data;
                     default: begin
                        r_memWe       <= 1'b1;
                        r_memWd       <= {in_data, r_asm};
                        r_wordsLoaded <= r_wordsLoaded + (ADDR_W+1)'(1);
                        if (w_lastWord) begin
                           r_state   <= S_TAIL;
                           r_inReady <= TAIL_READY;
                        end
                     end
                  endcase
               end
            end
`ifdef CODE_LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (w_xfer) begin
                  r_inReady <= 1'b0;
                  r_state   <= (in_data == r_xor) ? S_DONE : S_ERR;
               end
            end
`endif
            default: begin
               r_inReady <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready     = r_inReady;
   assign mem_we       = r_memWe;
   assign mem_addr     = r_memAddr;
   assign mem_wd       = r_memWd;
   assign cpu_resetn   = r_cpuResetn;
   assign done         = r_done;
   assign error        = r_error;
   assign words_loaded = r_wordsLoaded;

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: random byte streams and gaps checked against a word-level image model.
// Define CODE_LOADER_CHECKSUM_EN for both files to exercise the trailing checksum byte.
module tb_code_loader;

   localparam int CODE_WORDS = 512;
   localparam int ADDR_W     = 9;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wd;
   logic              cpu_resetn;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   words_loaded;

   code_loader #(.CODE_WORDS(CODE_WORDS), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
      .cpu_resetn(cpu_resetn), .done(done), .error(error), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   // Free-running cycle count used to time each write against the 4th byte of its word
   int cycleCount = 0;
   always @(posedge clk) cycleCount <= cycleCount + 1;

   int testsRun = 0;
   int testsFailed = 0;

   logic [ADDR_W-1:0] wrAddrQ[$];
   logic [31:0]       wrDataQ[$];
   int                wrCycleQ[$];
   logic [7:0]        txBytes[$];
   int                expCycleQ[$];

   // Every write pulse the DUT produces is logged for later comparison with the image
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wrAddrQ.push_back(mem_addr);
         wrDataQ.push_back(mem_wd);
         wrCycleQ.push_back(cycleCount);
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyReset(input bit checkIt);
      @(negedge clk);
      resetn = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      if (checkIt) begin
         checkOutput("reset.flags", {cpu_resetn, in_ready, mem_we, done, error}, 64'd0);
         checkOutput("reset.addr", mem_addr, 64'd0);
         checkOutput("reset.wd", mem_wd, 64'd0);
         checkOutput("reset.words", words_loaded, 64'd0);
      end
      resetn = 1'b1;
      wrAddrQ.delete();
      wrDataQ.delete();
      wrCycleQ.delete();
      repeat (2) @(negedge clk);
      if (checkIt) checkOutput("reset.readyAfter", in_ready, 64'd1);
   endtask

   task automatic sendByte(input logic [7:0] b, input int gap, output int xferCycle);
      int waited = 0;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data = b;
      while (in_ready !== 1'b1 && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      if (in_ready !== 1'b1) begin
         checkOutput("readyTimeout", {63'd0, in_ready}, 64'd1);
         xferCycle = -1;
      end else begin
         @(posedge clk);
         xferCycle = cycleCount;
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   // Streams txBytes; each word's write is expected in the cycle after its 4th byte is taken
   task automatic applyStimulus(input int nWords, input int gapMax);
      int c;
      int gap;
      expCycleQ.delete();
      for (int i = 0; i < txBytes.size(); i++) begin
         gap = (gapMax == 0) ? 0 : int'($urandom_range(gapMax, 0));
         sendByte(txBytes[i], gap, c);
         if (i >= 2 && i < 2 + 4 * nWords && ((i - 2) % 4) == 3) expCycleQ.push_back(c + 1);
      end
   endtask

   task automatic appendCsum(input logic [7:0] flip);
`ifdef CODE_LOADER_CHECKSUM_EN
      logic [7:0] x = flip;
      for (int i = 2; i < txBytes.size(); i++) x = x ^ txBytes[i];
      txBytes.push_back(x);
`endif
   endtask

   task automatic makeImage(input int nWords);
      txBytes.delete();
      txBytes.push_back(8'(nWords));
      txBytes.push_back(8'(nWords >> 8));
      for (int i = 0; i < 4 * nWords; i++) txBytes.push_back(8'($urandom));
      appendCsum(8'h00);
   endtask

   task automatic checkLoad(input string name, input int expWrites, input bit expectOk);
      int waited = 0;
      logic [31:0] expWord;
      repeat (2) @(negedge clk);
      while (done !== 1'b1 && error !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checkOutput({name, ".done"}, done, 64'(expectOk));
      checkOutput({name, ".error"}, error, 64'(!expectOk));
      checkOutput({name, ".cpuResetn"}, cpu_resetn, 64'(expectOk));
      checkOutput({name, ".inReady"}, in_ready, 64'd0);
      checkOutput({name, ".wordsLoaded"}, words_loaded, 64'(expWrites));
      checkOutput({name, ".writes"}, wrDataQ.size(), 64'(expWrites));
      if (expWrites > 0) checkOutput({name, ".addrFinal"}, mem_addr, 64'(expWrites - 1));
      for (int i = 0; i < expWrites && i < wrDataQ.size(); i++) begin
         expWord = 32'(txBytes[2 + 4 * i])
                 + (32'(txBytes[3 + 4 * i]) * 32'h100)
                 + (32'(txBytes[4 + 4 * i]) * 32'h10000)
                 + (32'(txBytes[5 + 4 * i]) * 32'h1000000);
         checkOutput($sformatf("%s.addr%0d", name, i), wrAddrQ[i], 64'(i));
         checkOutput($sformatf("%s.data%0d", name, i), wrDataQ[i], 64'(expWord));
         if (i < expCycleQ.size())
            checkOutput($sformatf("%s.latency%0d", name, i), wrCycleQ[i], 64'(expCycleQ[i]));
      end
   endtask

   initial begin
      int n;
      applyReset(1'b1);

      txBytes = '{8'h02, 8'h00, 8'h01, 8'h10, 8'hA0, 8'hE3, 8'h02, 8'h20, 8'h81, 8'hE2};
      appendCsum(8'h00);
      applyStimulus(2, 0);
      checkLoad("plan2w", 2, 1'b1);
      if (wrDataQ.size() == 2) begin
         checkOutput("plan2w.word0", wrDataQ[0], 64'hE3A01001);
         checkOutput("plan2w.word1", wrDataQ[1], 64'hE2812002);
      end

      applyReset(1'b0);
      txBytes = '{8'h00, 8'h00};
      appendCsum(8'h00);
      applyStimulus(0, 0);
      checkLoad("zeroLen", 0, 1'b1);

      applyReset(1'b0);
      txBytes = '{8'h01, 8'h02};
      applyStimulus(0, 0);
      checkLoad("tooLong", 0, 1'b0);

      applyReset(1'b0);
      makeImage(CODE_WORDS);
      applyStimulus(CODE_WORDS, 0);
      checkLoad("fullMem", CODE_WORDS, 1'b1);

      applyReset(1'b0);
      makeImage(3);
      applyStimulus(3, 0);
      checkLoad("gapless3", 3, 1'b1);
      applyReset(1'b0);
      applyStimulus(3, 3);
      checkLoad("gapped3", 3, 1'b1);

      applyReset(1'b0);
      txBytes = '{8'h02, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
      applyStimulus(2, 0);
      applyReset(1'b1);
      txBytes = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      appendCsum(8'h00);
      applyStimulus(1, 0);
      checkLoad("reload", 1, 1'b1);
      if (wrDataQ.size() == 1) checkOutput("reload.word0", wrDataQ[0], 64'h44332211);

      for (int t = 0; t < 6; t++) begin
         applyReset(1'b0);
         n = int'($urandom_range(8, 1));
         makeImage(n);
         applyStimulus(n, 2);
         checkLoad($sformatf("rand%0d", t), n, 1'b1);
      end

`ifdef CODE_LOADER_CHECKSUM_EN
      applyReset(1'b0);
      txBytes = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
      applyStimulus(1, 0);
      checkLoad("csumGood", 1, 1'b1);

      applyReset(1'b0);
      txBytes = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
      applyStimulus(1, 0);
      checkLoad("csumBad", 1, 1'b0);

      applyReset(1'b0);
      makeImage(4);
      txBytes[txBytes.size() - 1] = txBytes[txBytes.size() - 1] ^ 8'h80;
      applyStimulus(4, 1);
      checkLoad("csumRandBad", 4, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
